// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler sharing one flex_counter between NUM_REQ requesters.
//
// Each requester asks for a delay (in clock cycles) on its req_delay slice. The block grants
// the counter to one requester at a time, clears it, lets it count up to the requested value
// and then pulses that requester's done bit for one cycle.
//
// Ports:
//   clk               in   system clock, rising edge
//   nrst              in   asynchronous active-low reset (also resets the shared counter)
//   req               in   per-requester delay request (level), sampled only when idle
//   req_delay         in   packed delays, slice i = [i*NUM_BITS +: NUM_BITS]
//   gnt               out  registered one-hot grant, held for the whole service
//   done              out  registered one-hot, one-cycle completion pulse
//   busy              out  high whenever the scheduler is not idle
//   cnt_clear         out  flex_counter clear
//   cnt_enable        out  flex_counter count_enable
//   cnt_rollover_val  out  flex_counter rollover_val (registered, holds after service)
//   cnt_rollover_flag in   flex_counter rollover_flag
//
// Optional feature macro: TIMER_SCHED_ABORT_EN
//   When defined, a requester dropping its req while being served (clear or count phase)
//   aborts the service: the counter is cleared, no done pulse is produced, and the
//   aborted requester moves to the back of the round-robin order.

module timer_sched #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_BITS = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_delay,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic                        cnt_clear,
  output logic                        cnt_enable,
  output logic [NUM_BITS-1:0]         cnt_rollover_val,
  input  logic                        cnt_rollover_flag
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Pointer starts on the last requester so that requester 0 wins the first arbitration.
  localparam logic [IdxW-1:0]    LastInit = IdxW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] OneReq   = NUM_REQ'(1);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StCount,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [NUM_BITS-1:0] rval_q, rval_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;

  // Round-robin arbitration result
  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;
  logic [NUM_BITS-1:0] pick_delay;
  logic [IdxW-1:0]     cand;
  int unsigned         sum;

  // Search from last+1 upward, wrapping modulo NUM_REQ; the first set bit wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    sum        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      sum = 32'(last_q) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = IdxW'(sum);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_delay = req_delay[pick_idx*NUM_BITS +: NUM_BITS];

  // Next-state and counter-control outputs
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    rval_d     = rval_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          idx_d = pick_idx;
          gnt_d = OneReq << pick_idx;
          if (pick_delay != '0) begin
            rval_d  = pick_delay;
            state_d = StClear;
          end else begin
            // Zero delay never touches the counter: grant and done share one cycle.
            done_d  = OneReq << pick_idx;
            state_d = StDone;
          end
        end
      end

      StClear: begin
        cnt_clear = 1'b1;
        state_d   = StCount;
      end

      StCount: begin
        // Stop counting once the flag is seen so the counter parks at D instead of
        // rolling over to 1.
        cnt_enable = ~cnt_rollover_flag;
        if (cnt_rollover_flag) begin
          done_d  = OneReq << idx_q;
          state_d = StDone;
        end
      end

      StDone: begin
        last_d  = idx_q;
        gnt_d   = '0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase

`ifdef TIMER_SCHED_ABORT_EN
    // Requester withdrew mid-service: clear the counter and give up the grant silently.
    if ((state_q == StClear || state_q == StCount) && !req[idx_q]) begin
      state_d    = StIdle;
      gnt_d      = '0;
      done_d     = '0;
      last_d     = idx_q;
      cnt_clear  = 1'b1;
      cnt_enable = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      last_q  <= LastInit;
      idx_q   <= '0;
      rval_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      rval_q  <= rval_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign busy             = (state_q != StIdle);
  assign cnt_rollover_val = rval_q;

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched with a behavioural flex_counter model.
module tb_timer_sched;

  logic        clk;
  logic        nrst;
  logic [3:0]  req;
  logic [15:0] req_delay;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        cnt_clear;
  logic        cnt_enable;
  logic [3:0]  cnt_rollover_val;
  logic        cnt_rollover_flag;
  logic [3:0]  count_out;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    int idx;
    int delay;
  } exp_t;

  exp_t sb_q[$];

  timer_sched #(
    .NUM_REQ (4),
    .NUM_BITS(4)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .req              (req),
    .req_delay        (req_delay),
    .gnt              (gnt),
    .done             (done),
    .busy             (busy),
    .cnt_clear        (cnt_clear),
    .cnt_enable       (cnt_enable),
    .cnt_rollover_val (cnt_rollover_val),
    .cnt_rollover_flag(cnt_rollover_flag)
  );

  // Behavioural flex_counter: counts 1..rollover_val, flag registered on reaching it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_out         <= 4'd0;
      cnt_rollover_flag <= 1'b0;
    end else if (cnt_clear) begin
      count_out         <= 4'd0;
      cnt_rollover_flag <= 1'b0;
    end else if (cnt_enable) begin
      if (count_out == cnt_rollover_val) begin
        count_out         <= 4'd1;
        cnt_rollover_flag <= (cnt_rollover_val == 4'd1);
      end else begin
        count_out         <= count_out + 4'd1;
        cnt_rollover_flag <= ((count_out + 4'd1) == cnt_rollover_val);
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(input int idx, input int delay);
    exp_t e;
    e.idx   = idx;
    e.delay = delay;
    sb_q.push_back(e);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    nrst      = 1'b0;
    req       = 4'b0000;
    req_delay = 16'h0000;
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    nrst      = 1'b0;
    req       = 4'b1111;
    req_delay = 16'h3333;
    @(negedge clk);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      tests_run++;
      if (gnt !== 4'b0000) begin
        tests_failed++; $display("FAIL reset_gnt[%0d]: got %b, expected 0000", p, gnt);
      end
      tests_run++;
      if (done !== 4'b0000) begin
        tests_failed++; $display("FAIL reset_done[%0d]: got %b, expected 0000", p, done);
      end
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++; $display("FAIL reset_busy[%0d]: got %b, expected 0", p, busy);
      end
      tests_run++;
      if (cnt_clear !== 1'b0) begin
        tests_failed++; $display("FAIL reset_clear[%0d]: got %b, expected 0", p, cnt_clear);
      end
      tests_run++;
      if (cnt_enable !== 1'b0) begin
        tests_failed++; $display("FAIL reset_enable[%0d]: got %b, expected 0", p, cnt_enable);
      end
      tests_run++;
      if (cnt_rollover_val !== 4'd0) begin
        tests_failed++;
        $display("FAIL reset_rval[%0d]: got %0d, expected 0", p, cnt_rollover_val);
      end
      if (p == 0) begin
        // Release at a negedge and look again before any rising edge.
        nrst = 1'b1;
        #1;
      end
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_single();
    exp_t e;
    int   rise, gnt_cycles, done_cycles;
    bit   seen5, wrapped;
    do_reset();
    req_delay = 16'h0005;
    push_exp(0, 5);
    req = 4'b0001;
    rise = -1; gnt_cycles = 0; done_cycles = 0; seen5 = 0; wrapped = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin
        if (rise < 0) rise = cyc;
        gnt_cycles++;
        tests_run++;
        if (gnt !== 4'b0001) begin
          tests_failed++; $display("FAIL single_gnt_value: got %b, expected 0001", gnt);
        end
      end
      if (count_out == 4'd5) seen5 = 1;
      else if (seen5 && count_out == 4'd1) wrapped = 1;
      if (done !== 4'b0000) begin
        done_cycles++;
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL single_extra_done: got %b, expected 0000", done);
        end else begin
          e = sb_q.pop_front();
          if (done !== 4'(1 << e.idx)) begin
            tests_failed++; $display("FAIL single_done_idx: got %b, expected idx %0d", done, e.idx);
          end
          tests_run++;
          if (cyc - rise !== e.delay + 2) begin
            tests_failed++;
            $display("FAIL single_done_cycle: got %0d, expected %0d", cyc - rise, e.delay + 2);
          end
          tests_run++;
          if (count_out !== 4'(e.delay)) begin
            tests_failed++; $display("FAIL single_count_at_done: got %0d, expected %0d",
                                     count_out, e.delay);
          end
          tests_run++;
          if (cnt_rollover_flag !== 1'b1) begin
            tests_failed++; $display("FAIL single_flag_at_done: got %b, expected 1",
                                     cnt_rollover_flag);
          end
        end
        req = 4'b0000;
      end
    end
    tests_run++;
    if (gnt_cycles !== 8) begin
      tests_failed++; $display("FAIL single_gnt_len: got %0d, expected 8", gnt_cycles);
    end
    tests_run++;
    if (done_cycles !== 1) begin
      tests_failed++; $display("FAIL single_done_len: got %0d, expected 1", done_cycles);
    end
    tests_run++;
    if (wrapped !== 1'b0) begin
      tests_failed++; $display("FAIL single_no_wrap: got %b, expected 0", wrapped);
    end
    tests_run++;
    if (sb_q.size() !== 0) begin
      tests_failed++; $display("FAIL single_missing_done: got %0d pending, expected 0", sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    exp_t       e;
    int         rise, prev_rise;
    logic [3:0] prev_gnt;
    do_reset();
    req_delay = 16'h3333;
    push_exp(0, 3); push_exp(1, 3); push_exp(2, 3); push_exp(3, 3); push_exp(0, 3);
    req = 4'b1111;
    rise = -1; prev_rise = -1; prev_gnt = 4'b0000;
    for (int c = 0; c < 60 && sb_q.size() > 0; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
        rise = cyc;
        if (prev_rise >= 0) begin
          tests_run++;
          if (rise - prev_rise !== 7) begin
            tests_failed++; $display("FAIL rr_period: got %0d, expected 7", rise - prev_rise);
          end
        end
        prev_rise = rise;
      end
      if (done !== 4'b0000) begin
        e = sb_q.pop_front();
        tests_run++;
        if (done !== 4'(1 << e.idx) || gnt !== 4'(1 << e.idx)) begin
          tests_failed++;
          $display("FAIL rr_order: got done %b gnt %b, expected idx %0d", done, gnt, e.idx);
        end
        tests_run++;
        if (cyc - rise !== e.delay + 2) begin
          tests_failed++;
          $display("FAIL rr_done_cycle: got %0d, expected %0d", cyc - rise, e.delay + 2);
        end
        if (sb_q.size() == 0) req = 4'b0000;
      end
      prev_gnt = gnt;
    end
    tests_run++;
    if (sb_q.size() !== 0) begin
      tests_failed++; $display("FAIL rr_timeout: got %0d pending, expected 0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL rr_idle_after: got %b, expected 0", busy);
    end
  endtask

  task automatic test_zero_delay();
    exp_t e;
    int   gnt_cycles, done_cycles, together;
    bit   ctrl_seen;
    do_reset();
    req_delay = 16'h5055;  // slice 2 = 0
    push_exp(2, 0);
    req = 4'b0100;
    gnt_cycles = 0; done_cycles = 0; together = 0; ctrl_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cnt_clear || cnt_enable) ctrl_seen = 1;
      if (gnt !== 4'b0000) gnt_cycles++;
      if (done !== 4'b0000) begin
        done_cycles++;
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL zero_extra_done: got %b, expected 0000", done);
        end else begin
          e = sb_q.pop_front();
          if (done !== 4'(1 << e.idx) || gnt !== 4'(1 << e.idx)) begin
            tests_failed++;
            $display("FAIL zero_same_cycle: got done %b gnt %b, expected 0100 both", done, gnt);
          end else begin
            together++;
          end
        end
        req = 4'b0000;
      end
    end
    tests_run++;
    if (gnt_cycles !== 1 || done_cycles !== 1 || together !== 1) begin
      tests_failed++;
      $display("FAIL zero_len: got gnt %0d done %0d, expected 1 1", gnt_cycles, done_cycles);
    end
    tests_run++;
    if (ctrl_seen !== 1'b0) begin
      tests_failed++; $display("FAIL zero_counter_untouched: got %b, expected 0", ctrl_seen);
    end
  endtask

  task automatic test_max_delay();
    exp_t e;
    int   rise;
    do_reset();
    req_delay = 16'h00F0;  // slice 1 = 15
    push_exp(1, 15);
    req = 4'b0010;
    rise = -1;
    for (int c = 0; c < 30 && sb_q.size() > 0; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000 && rise < 0) rise = cyc;
      if (done !== 4'b0000) begin
        e = sb_q.pop_front();
        tests_run++;
        if (done !== 4'(1 << e.idx)) begin
          tests_failed++; $display("FAIL max_done_idx: got %b, expected 0010", done);
        end
        tests_run++;
        if (cyc - rise !== e.delay + 2) begin
          tests_failed++;
          $display("FAIL max_done_cycle: got %0d, expected %0d", cyc - rise, e.delay + 2);
        end
        req = 4'b0000;
      end
    end
    tests_run++;
    if (sb_q.size() !== 0) begin
      tests_failed++; $display("FAIL max_timeout: got %0d pending, expected 0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL max_idle_busy: got %b, expected 0", busy);
    end
    tests_run++;
    if (cnt_rollover_val !== 4'd15) begin
      tests_failed++; $display("FAIL max_rval_hold: got %0d, expected 15", cnt_rollover_val);
    end
  endtask

  task automatic test_drop();
    exp_t e;
    int   rise;
    bit   dropped;
    do_reset();
    req_delay = 16'h0009;
`ifndef TIMER_SCHED_ABORT_EN
    push_exp(0, 9);
`endif
    req = 4'b0001;
    rise = -1; dropped = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000 && rise < 0) rise = cyc;
`ifdef TIMER_SCHED_ABORT_EN
      if (dropped && cyc == rise + 3) begin
        tests_run++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || count_out !== 4'd0) begin
          tests_failed++;
          $display("FAIL abort_after: got busy %b gnt %b count %0d, expected 0 0000 0",
                   busy, gnt, count_out);
        end
      end
`endif
      if (done !== 4'b0000) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL drop_extra_done: got %b, expected 0000", done);
        end else begin
          e = sb_q.pop_front();
          if (done !== 4'(1 << e.idx)) begin
            tests_failed++; $display("FAIL drop_done_idx: got %b, expected 0001", done);
          end
          tests_run++;
          if (cyc - rise !== e.delay + 2) begin
            tests_failed++;
            $display("FAIL drop_done_cycle: got %0d, expected %0d", cyc - rise, e.delay + 2);
          end
        end
      end
      if (rise >= 0 && !dropped && cyc == rise + 2) begin
        // Two COUNT cycles have elapsed; withdraw the request.
        dropped = 1;
        req     = 4'b0000;
`ifdef TIMER_SCHED_ABORT_EN
        #1;
        tests_run++;
        if (cnt_clear !== 1'b1 || cnt_enable !== 1'b0 || done !== 4'b0000) begin
          tests_failed++;
          $display("FAIL abort_cycle: got clear %b enable %b done %b, expected 1 0 0000",
                   cnt_clear, cnt_enable, done);
        end
`endif
      end
    end
    tests_run++;
    if (sb_q.size() !== 0 || !dropped) begin
      tests_failed++;
      $display("FAIL drop_missing_done: got %0d pending dropped %b, expected 0 1",
               sb_q.size(), dropped);
    end
  endtask

  initial begin
    nrst      = 1'b0;
    req       = 4'b0000;
    req_delay = 16'h0000;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_delay();
    test_max_delay();
    test_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Round-robin scheduler that shares one flex_counter instance between NUM_REQ requesters. Each requester asks for a delay in clock cycles.
- The block grants the counter to one requester at a time and drives the counter's clear, count_enable and rollover_val inputs. It watches rollover_flag and pulses a per-requester done when the delay has elapsed.
- Sits between client FSMs and the shared flex_counter; bench instantiates timer_sched plus flex_counter (NUM_BITS matched).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_BITS, 4, counter width; must equal flex_counter NUM_BITS.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester delay request, level.
- req_delay  in  NUM_REQ*NUM_BITS  requested delay; slice i = bits [i*NUM_BITS +: NUM_BITS].
- gnt  out  NUM_REQ  one-hot grant, registered.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse, registered.
- busy  out  1  high when state != IDLE.
- cnt_clear  out  1  to flex_counter clear.
- cnt_enable  out  1  to flex_counter count_enable.
- cnt_rollover_val  out  NUM_BITS  to flex_counter rollover_val, registered.
- cnt_rollover_flag  in  1  from flex_counter rollover_flag.

Behaviour:
- Reset values:
  - state = IDLE.
  - gnt, done, cnt_clear, cnt_enable, cnt_rollover_val = 0.
  - Round-robin pointer last = NUM_REQ-1, so req[0] wins first.
- States: IDLE, CLEAR, COUNT, DONE.
- IDLE:
  - If req is nonzero, select the first set bit searching from last+1 upward, wrapping modulo NUM_REQ.
  - Latch that requester's index and req_delay slice (D). Set gnt one-hot.
  - If D != 0, go to CLEAR and load cnt_rollover_val = D.
  - If D == 0, go straight to DONE; the counter is untouched.
  - req and req_delay are sampled only in IDLE.
- CLEAR:
  - cnt_clear = 1 and cnt_enable = 0 for exactly one cycle.
  - Next state is COUNT.
- COUNT:
  - cnt_enable = ~cnt_rollover_flag (combinational from state and flag). The counter stops at D and never rolls to 1.
  - When cnt_rollover_flag = 1, go to DONE.
- DONE:
  - done[idx] = 1 for one cycle; gnt still held; cnt_enable = 0.
  - Update last = idx, clear gnt, next state is IDLE.
- Latency, D != 0 (cycle 0 = first cycle gnt is high):
  - CLEAR = cycle 0.
  - Counter reaches D at the end of cycle D.
  - Flag is seen in cycle D+1.
  - done is high in cycle D+2.
  - gnt is high for D+3 cycles.
- Latency, D == 0: gnt and done are both high in the same single cycle.
- Idle gap: at least one IDLE cycle between grants. The next grant can appear the cycle after DONE, so the back-to-back period is D+4.
- req[idx] dropping during service is ignored (service completes); see Optional Feature.
- cnt_rollover_val holds its value after DONE until the next grant loads a new one.
- Reset mid-operation: immediate return to reset values. The counter is reset by the same nrst.
- Changes to req_delay during service have no effect.

Optional Feature:
- Macro: TIMER_SCHED_ABORT_EN.
- Defined:
  - In CLEAR or COUNT, if req[idx] = 0, go to IDLE next cycle; no done pulse.
  - cnt_clear = 1 and cnt_enable = 0 in that abort cycle; gnt clears on the transition.
  - last = idx, so the aborted requester loses priority.
- Undefined: req is ignored outside IDLE, as described above.

Test Plan:
- Reset: hold nrst = 0 with req = 4'b1111 → gnt = 0, done = 0, busy = 0, cnt_clear = 0, cnt_enable = 0, cnt_rollover_val = 0, both during reset and after release at negedge.
- Single request: req = 4'b0001, delay0 = 5 → gnt = 0001 for 8 cycles; done[0] high in cycle 7 only; flex_counter count_out = 5 with rollover_flag = 1 at done; count_out never shows 1 after 5.
- Round robin: req = 4'b1111, all delays = 3 → grant order 0, 1, 2, 3, 0; each done follows its gnt by 5 cycles; successive grant rises are 7 cycles apart.
- Zero delay: req = 4'b0100, delay2 = 0 → gnt = 0100 and done = 0100 in the same single cycle; cnt_clear and cnt_enable stay 0.
- Max delay and idle hold: delay1 = 15, req = 4'b0010 → done[1] 17 cycles after gnt rises. Then drop req → busy = 0, and cnt_rollover_val stays 15.
- Mid-service request drop: req[0] drops after 2 COUNT cycles with delay0 = 9.
  - Macro undefined: service completes and done[0] still pulses.
  - TIMER_SCHED_ABORT_EN defined: cnt_clear pulses, no done, busy = 0 the next cycle, and count_out = 0 after the following edge.
